// File: rtl/pr_write_coalescer.sv
// Write coalescer for PageRank results: merges 8-byte words that share a
// 64-byte line into single-beat 512-bit AXI writes and tracks open B responses.
module pr_write_coalescer #(
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned TIMEOUT         = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_addr,
  input  logic [63:0]  in_data,
  input  logic         flush,
  output logic         flush_done,
  output logic [15:0]  awid_m,
  output logic [63:0]  awaddr_m,
  output logic [7:0]   awlen_m,
  output logic [2:0]   awsize_m,
  output logic         awvalid_m,
  input  logic         awready_m,
  output logic [15:0]  wid_m,
  output logic [511:0] wdata_m,
  output logic [63:0]  wstrb_m,
  output logic         wlast_m,
  output logic         wvalid_m,
  input  logic         wready_m,
  input  logic [15:0]  bid_m,
  input  logic [1:0]   bresp_m,
  input  logic         bvalid_m,
  output logic         bready_m,
  output logic [7:0]   outstanding,
  output logic [31:0]  lines_written,
  output logic         bresp_err
);

  typedef enum logic [1:0] {EMPTY, FILL, ISSUE} state_t;

  localparam logic [7:0]  MAX_OUT  = 8'(MAX_OUTSTANDING);
  localparam logic [31:0] IDLE_END = 32'(TIMEOUT - 1);

  state_t      state;
  logic [57:0] tag;
  logic [63:0] lane_data [8];
  logic [7:0]  strb;
  logic [31:0] idle_cnt;
  logic        aw_pend;
  logic        w_pend;
  logic        flush_pending;

  logic [57:0] in_tag;
  logic [2:0]  in_lane;
  logic [7:0]  lane_bit;
  logic        tag_match;
  logic        accept;
  logic        aw_hs;
  logic        w_hs;
  logic        b_ok;
  logic        aw_left;
  logic        w_left;
  logic        flush_req;
  logic        line_full;
  logic        mismatch;
  logic        idle_expired;
  logic        unused_ok;

  always_comb begin
    awid_m    = '0;
    wid_m     = '0;
    awlen_m   = '0;
    awsize_m  = 3'b110;
    wlast_m   = 1'b1;
    bready_m  = 1'b1;
    awaddr_m  = {tag, 6'b0};
    unused_ok = ^{bid_m, in_addr[2:0]};
  end

  always_comb begin
    in_tag    = in_addr[63:6];
    in_lane   = in_addr[5:3];
    lane_bit  = 8'b1 << in_lane;
    tag_match = (in_tag == tag);
    case (state)
      EMPTY:   in_ready = 1'b1;
      FILL:    in_ready = tag_match;
      default: in_ready = 1'b0;
    endcase
    accept       = in_valid & in_ready;
    mismatch     = in_valid & ~tag_match;
    line_full    = &(strb | (accept ? lane_bit : 8'h00));
    idle_expired = ~accept && (idle_cnt == IDLE_END);
    flush_req    = flush | flush_pending;
    // AW is held off (never withdrawn) once the B window is full.
    awvalid_m    = aw_pend && (outstanding != MAX_OUT);
    wvalid_m     = w_pend;
    aw_hs        = awvalid_m & awready_m;
    w_hs         = wvalid_m & wready_m;
    aw_left      = aw_pend & ~aw_hs;
    w_left       = w_pend & ~w_hs;
    b_ok         = bvalid_m && (outstanding != 8'd0);
  end

  // Lane 0 occupies the MSBs; unwritten lanes are driven as zero.
  always_comb begin
    wdata_m = '0;
    wstrb_m = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      wdata_m[64*(8-k)-1 -: 64] = strb[k] ? lane_data[k] : 64'd0;
      wstrb_m[8*(8-k)-1 -: 8]   = {8{strb[k]}};
    end
  end

  always_ff @(posedge clk) begin
    if (accept) lane_data[in_lane] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= EMPTY;
      tag           <= '0;
      strb          <= '0;
      idle_cnt      <= '0;
      aw_pend       <= 1'b0;
      w_pend        <= 1'b0;
      flush_pending <= 1'b0;
      flush_done    <= 1'b0;
      outstanding   <= '0;
      lines_written <= '0;
      bresp_err     <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case ({aw_hs, b_ok})
        2'b10:   outstanding <= outstanding + 8'd1;
        2'b01:   outstanding <= outstanding - 8'd1;
        default: outstanding <= outstanding;
      endcase
      if (w_hs) lines_written <= lines_written + 32'd1;
      if (bvalid_m && (bresp_m != 2'b00)) bresp_err <= 1'b1;

      case (state)
        EMPTY: begin
          idle_cnt <= '0;
          if (accept) begin
            tag           <= in_tag;
            strb          <= lane_bit;
            state         <= FILL;
            flush_pending <= flush_req;
          end else if (flush_req && (outstanding == 8'd0)) begin
            flush_done    <= 1'b1;
            flush_pending <= 1'b0;
          end else begin
            flush_pending <= flush_req;
          end
        end
        FILL: begin
          flush_pending <= flush_req;
          if (accept) begin
            strb     <= strb | lane_bit;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
          end
          if (mismatch || line_full || flush_req || idle_expired) begin
            state    <= ISSUE;
            aw_pend  <= 1'b1;
            w_pend   <= 1'b1;
            idle_cnt <= '0;
          end
        end
        ISSUE: begin
          flush_pending <= flush_req;
          aw_pend       <= aw_left;
          w_pend        <= w_left;
          if (!aw_left && !w_left) begin
            strb  <= '0;
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: doc/pr_write_coalescer.md
Name: pr_write_coalescer

Overview:
- Sits directly downstream of the PageRank logic stage. It accepts the per-vertex 64-bit PageRank results, one word and one address at a time.
- It merges words that fall in the same 64-byte line into a single full-line AXI write with byte strobes.
- It replaces the current pattern of one 8-byte single-beat write per vertex, and tracks outstanding B responses so the round controller knows when all writes have landed.

Parameters:
- MAX_OUTSTANDING, 8, max AW issued without a B response (1..255)
- TIMEOUT, 64, idle cycles in FILL before a partial line is flushed automatically (>=1)

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  PR word valid
- in_ready  out  1  PR word accepted when in_valid&in_ready
- in_addr  in  64  byte address of word, 8-byte aligned
- in_data  in  64  PageRank value
- flush  in  1  single-cycle request: drain partial line, report when all B received
- flush_done  out  1  one-cycle pulse: no line buffered and zero outstanding after flush
- awid_m/awaddr_m/awlen_m/awsize_m/awvalid_m  out  16/64/8/3/1  AXI AW
- awready_m  in  1
- wid_m/wdata_m/wstrb_m/wlast_m/wvalid_m  out  16/512/64/1/1  AXI W
- wready_m  in  1
- bid_m  in  16;  bresp_m  in  2;  bvalid_m  in  1;  bready_m  out  1
- outstanding  out  8  AW issued minus B received
- lines_written  out  32  count of completed W handshakes
- bresp_err  out  1  sticky: any bresp_m != 0

Behaviour:
- Reset (reset_n low at clk edge, in any state, including mid-ISSUE):
  - state=EMPTY; line buffer strobes cleared.
  - awvalid_m=wvalid_m=0; flush_done=0.
  - outstanding=0, lines_written=0, bresp_err=0; idle counter=0; pending flush cleared.
- Constant outputs: awid_m=0, wid_m=0, awlen_m=0, awsize_m=3'b110, wlast_m=1, bready_m=1.
- Line tag = in_addr[63:6]; lane k = in_addr[5:3].
- Lane k data sits at wdata_m[64*(8-k)-1 : 64*(7-k)] and its strobe at wstrb_m[8*(8-k)-1 : 8*(7-k)]. Lane 0 is in the MSBs, matching the existing PR write packing.
- awaddr_m = {tag, 6'b0}.
- States:
  - EMPTY:
    - in_ready=1.
    - On accept: latch tag, write lane, set its strobe, go to FILL.
    - On flush with outstanding==0: pulse flush_done next cycle. With outstanding>0: hold the flush pending until outstanding reaches 0, then pulse.
  - FILL:
    - in_ready=1 only if in_addr tag == latched tag. in_ready is combinational and is 0 for a mismatched tag.
    - Same-tag accept: write lane and set its strobe. A rewrite of an already-set lane overwrites the data (last wins).
    - Idle counter resets on every accept and increments otherwise.
    - Go to ISSUE next cycle if any of the following holds:
      - (a) in_valid with a mismatched tag;
      - (b) all 8 strobes set, including the accept that completes the line;
      - (c) flush;
      - (d) idle counter reaches TIMEOUT-1.
    - The mismatched word stays on the input, not accepted, until the block returns to EMPTY.
  - ISSUE:
    - in_ready=0.
    - awvalid_m=1, gated low while outstanding==MAX_OUTSTANDING. wvalid_m=1 independently.
    - Each valid drops after its own handshake. AW and W may complete in either order or in the same cycle.
    - When both have completed: clear strobes and go to EMPTY. A flush seen in FILL or ISSUE becomes pending.
    - Unstrobed lanes drive 0 in wdata_m.
- outstanding:
  - +1 on an AW handshake, -1 on bvalid_m.
  - Both in the same cycle: no change.
  - A B response at outstanding==0 is ignored and must not occur.
- lines_written increments on each W handshake and wraps at 2^32.
- bresp_err is set on bvalid_m with bresp_m!=0 and cleared only by reset.
- Latency:
  - A full line accepted at cycle N: awvalid/wvalid are high at N+1.
  - Back-to-back lines through the block: at least 3 cycles each (accept..ISSUE..EMPTY) when AXI ready is tied high.
- flush_done fires exactly once per flush request: when the state is EMPTY, no flush is queued behind an unissued line, and outstanding==0.

Test Plan:
- Reset, then 8 words to 0x1000,0x1008..0x1038 with data 1..8, AXI ready high → exactly one AW at 0x1000 with wstrb_m=all 1s. wdata_m[511:448]=1 and wdata_m[63:0]=8. lines_written=1.
- Words to 0x2008 then 0x2040 → line 0x2000 issued with wstrb_m=64'h00FF000000000000 (lane 1 only). in_ready=0 for 0x2040 until EMPTY, then it is accepted into line 0x2040.
- Word 0x3000=5 then 0x3000=9 in FILL, then flush → single write carrying 9 in lane 0. flush_done pulses exactly once, one cycle after bvalid returns outstanding to 0.
- awready_m low for 10 cycles while wready_m high → W completes first and AW stays asserted. The state stays ISSUE until the AW handshake, then goes to EMPTY.
- MAX_OUTSTANDING=2, bvalid withheld, 3 full lines offered → only 2 AW handshakes and awvalid_m held low on the third. One B (bresp=2'b10) releases it and sets bresp_err=1.
- Single word then no input for TIMEOUT cycles → automatic partial-line write. Asserting reset_n=0 mid-ISSUE → awvalid_m=wvalid_m=0 and outstanding=0 on the next cycle.
